// File: rtl/execute2_stage.sv
// execute2_stage: RV32IM E2 stage - ALU/M-ext, branch resolve, E2/M register.
// Iterative divider present only when RV32M_DIV_EN is defined; otherwise div/rem return 0.
module execute2_stage #(
    parameter int DIV_CYCLES = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] Src_A_E1,
    input  logic [XLEN-1:0] Src_B_E1,
    input  logic [XLEN-1:0] Imm_Ext_E1,
    input  logic [XLEN-1:0] WriteDataE1,
    input  logic [4:0]      ALUControlE1,
    input  logic [4:0]      RD_E1,
    input  logic            RegWriteE1,
    input  logic            MemWriteE1,
    input  logic [1:0]      ResultSrcE1,
    input  logic            BranchE1,
    input  logic            JumpE1,
    input  logic            JalrE1,
    input  logic [XLEN-1:0] PCE1,
    input  logic [XLEN-1:0] PCPlus4E1,
    input  logic [2:0]      LoadTypeE1,
    input  logic [2:0]      StoreTypeE1,
    input  logic [2:0]      funct3_E1,
    output logic [XLEN-1:0] ALU_ResultE2,
    output logic            StallE2,
    output logic            PCSrcE2,
    output logic [XLEN-1:0] PCTargetE2,
    output logic [XLEN-1:0] ALU_ResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RD_M,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [2:0]      LoadTypeM,
    output logic [2:0]      StoreTypeM
);
    localparam int SH_W = $clog2(XLEN);
    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
        OP_XOR = 5'd4, OP_SLT = 5'd5, OP_SLTU = 5'd6, OP_SLL = 5'd7, OP_SRL = 5'd8,
        OP_SRA = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11, OP_MULHSU = 5'd12, OP_MULHU = 5'd13,
        OP_DIV = 5'd14, OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17, OP_PASSB = 5'd18;

    logic [XLEN-1:0] a, b, alu_base, div_res;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic is_div, cond, taken;

    assign a = Src_A_E1;
    assign b = Src_B_E1;
    assign is_div = ALUControlE1 >= OP_DIV && ALUControlE1 <= OP_REMU;

    // Operands extended to 2*XLEN so one multiplier serves all four signedness variants
    assign mul_a = {{XLEN{(ALUControlE1 == OP_MULH || ALUControlE1 == OP_MULHSU) && a[XLEN-1]}}, a};
    assign mul_b = {{XLEN{ALUControlE1 == OP_MULH && b[XLEN-1]}}, b};
    assign prod = mul_a * mul_b;

    always_comb begin
        alu_base = '0;
        case (ALUControlE1)
            OP_ADD:    alu_base = a + b;
            OP_SUB:    alu_base = a - b;
            OP_AND:    alu_base = a & b;
            OP_OR:     alu_base = a | b;
            OP_XOR:    alu_base = a ^ b;
            OP_SLT:    alu_base = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:   alu_base = {{(XLEN-1){1'b0}}, a < b};
            OP_SLL:    alu_base = a << b[SH_W-1:0];
            OP_SRL:    alu_base = a >> b[SH_W-1:0];
            OP_SRA:    alu_base = $unsigned($signed(a) >>> b[SH_W-1:0]);
            OP_MUL:    alu_base = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_base = prod[2*XLEN-1:XLEN];
            OP_PASSB:  alu_base = b;
            default:   alu_base = '0;
        endcase
    end

    assign ALU_ResultE2 = is_div ? div_res : alu_base;

    always_comb begin
        case (funct3_E1)
            3'b000:  cond = a == b;
            3'b001:  cond = a != b;
            3'b100:  cond = $signed(a) < $signed(b);
            3'b101:  cond = $signed(a) >= $signed(b);
            3'b110:  cond = a < b;
            3'b111:  cond = a >= b;
            default: cond = 1'b0;
        endcase
    end

    assign taken = (BranchE1 & cond) | JumpE1 | JalrE1;
    assign PCSrcE2 = taken & ~StallE2;
    assign PCTargetE2 = JalrE1 ? ((a + Imm_Ext_E1) & {{(XLEN-1){1'b1}}, 1'b0}) : PCE1 + Imm_Ext_E1;

`ifdef RV32M_DIV_EN
    localparam int CNT_W = $clog2(DIV_CYCLES);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t state, state_nx;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0] quo, rem, dvs, abs_a, abs_b, q_fix, r_fix;
    logic [XLEN:0] shifted;
    logic neg_q, neg_r, div_signed, div_quot, div_zero, div_ovf, start, fits;

    assign div_signed = ALUControlE1 == OP_DIV || ALUControlE1 == OP_REM;
    assign div_quot = ALUControlE1 == OP_DIV || ALUControlE1 == OP_DIVU;
    assign div_zero = b == '0;
    assign div_ovf = div_signed && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
    assign start = is_div && !div_zero && !div_ovf;
    assign abs_a = (div_signed && a[XLEN-1]) ? -a : a;
    assign abs_b = (div_signed && b[XLEN-1]) ? -b : b;
    // Restoring step: shift next dividend bit into the partial remainder and trial-subtract
    assign shifted = {rem, quo[XLEN-1]};
    assign fits = shifted >= {1'b0, dvs};
    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    assign div_res = div_zero ? (div_quot ? '1 : a) :
                     div_ovf ? (div_quot ? a : '0) :
                     state == DONE ? (div_quot ? q_fix : r_fix) : '0;
    assign StallE2 = !rst && ((state == IDLE && start) || state == BUSY);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? BUSY : IDLE;
            BUSY:    state_nx = count == CNT_W'(DIV_CYCLES - 1) ? DONE : BUSY;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                quo <= abs_a;
                rem <= '0;
                dvs <= abs_b;
                count <= '0;
                neg_q <= div_signed && (a[XLEN-1] ^ b[XLEN-1]);
                neg_r <= div_signed && a[XLEN-1];
            end else if (state == BUSY) begin
                count <= count + 1'b1;
                quo <= {quo[XLEN-2:0], fits};
                rem <= fits ? XLEN'(shifted - {1'b0, dvs}) : shifted[XLEN-1:0];
            end
        end
    end
`else
    assign div_res = '0;
    assign StallE2 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_ResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M <= '0;
            RD_M <= '0;
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
            ResultSrcM <= '0;
            LoadTypeM <= '0;
            StoreTypeM <= '0;
        end else if (StallE2) begin
            RegWriteM <= 1'b0;
            MemWriteM <= 1'b0;
        end else begin
            ALU_ResultM <= ALU_ResultE2;
            WriteDataM <= WriteDataE1;
            PCPlus4M <= PCPlus4E1;
            RD_M <= RD_E1;
            RegWriteM <= RegWriteE1;
            MemWriteM <= MemWriteE1;
            ResultSrcM <= ResultSrcE1;
            LoadTypeM <= LoadTypeE1;
            StoreTypeM <= StoreTypeE1;
        end
    end
endmodule

// File: tb/tb_execute2_stage.sv
// tb_execute2_stage: randomized self-checking bench against a behavioural RV32IM model.
// Divider scenarios are compiled in when RV32M_DIV_EN is defined.
module tb_execute2_stage;
    logic clk = 1'b0;
    logic rst;
    logic [31:0] Src_A_E1, Src_B_E1, Imm_Ext_E1, WriteDataE1, PCE1, PCPlus4E1;
    logic [4:0] ALUControlE1, RD_E1;
    logic RegWriteE1, MemWriteE1, BranchE1, JumpE1, JalrE1;
    logic [1:0] ResultSrcE1;
    logic [2:0] LoadTypeE1, StoreTypeE1, funct3_E1;
    logic [31:0] ALU_ResultE2, PCTargetE2, ALU_ResultM, WriteDataM, PCPlus4M;
    logic StallE2, PCSrcE2, RegWriteM, MemWriteM;
    logic [4:0] RD_M;
    logic [1:0] ResultSrcM;
    logic [2:0] LoadTypeM, StoreTypeM;
    logic [78:0] m_pass, exp_pass;
    int checks = 0;
    int failures = 0;

    execute2_stage dut (
        .clk(clk), .rst(rst), .Src_A_E1(Src_A_E1), .Src_B_E1(Src_B_E1), .Imm_Ext_E1(Imm_Ext_E1),
        .WriteDataE1(WriteDataE1), .ALUControlE1(ALUControlE1), .RD_E1(RD_E1),
        .RegWriteE1(RegWriteE1), .MemWriteE1(MemWriteE1), .ResultSrcE1(ResultSrcE1),
        .BranchE1(BranchE1), .JumpE1(JumpE1), .JalrE1(JalrE1), .PCE1(PCE1), .PCPlus4E1(PCPlus4E1),
        .LoadTypeE1(LoadTypeE1), .StoreTypeE1(StoreTypeE1), .funct3_E1(funct3_E1),
        .ALU_ResultE2(ALU_ResultE2), .StallE2(StallE2), .PCSrcE2(PCSrcE2), .PCTargetE2(PCTargetE2),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RD_M(RD_M),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .LoadTypeM(LoadTypeM), .StoreTypeM(StoreTypeM)
    );

    always #5 clk = ~clk;
    assign m_pass = {WriteDataM, PCPlus4M, RD_M, RegWriteM, MemWriteM, ResultSrcM, LoadTypeM, StoreTypeM};

    function automatic logic [31:0] model_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        p = 0;
        case (op)
            5'd0:  p = ua + ub;
            5'd1:  p = ua - ub;
            5'd2:  p = ua & ub;
            5'd3:  p = ua | ub;
            5'd4:  p = ua ^ ub;
            5'd5:  p = (sa < sb) ? 1 : 0;
            5'd6:  p = (ua < ub) ? 1 : 0;
            5'd7:  p = ua << b[4:0];
            5'd8:  p = ua >> b[4:0];
            5'd9:  p = sa >>> b[4:0];
            5'd10: p = sa * sb;
            5'd11: p = (sa * sb) >> 32;
            5'd12: p = (sa * ub) >> 32;
            5'd13: p = (ua * ub) >> 32;
`ifdef RV32M_DIV_EN
            5'd14: p = (b == 0) ? -1 : ovf ? ua : sa / sb;
            5'd15: p = (b == 0) ? -1 : ua / ub;
            5'd16: p = (b == 0) ? ua : ovf ? 0 : sa % sb;
            5'd17: p = (b == 0) ? ua : ua % ub;
`endif
            5'd18: p = ub;
            default: p = 0;
        endcase
        return p[31:0];
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 4))
            0: return 32'($urandom_range(0, 40));
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        ALUControlE1 = op;
        Src_A_E1 = a;
        Src_B_E1 = b;
        Imm_Ext_E1 = $urandom;
        PCE1 = $urandom;
        PCPlus4E1 = PCE1 + 32'd4;
        WriteDataE1 = $urandom;
        RD_E1 = 5'($urandom);
        RegWriteE1 = 1'b1;
        MemWriteE1 = 1'($urandom);
        ResultSrcE1 = 2'($urandom);
        LoadTypeE1 = 3'($urandom);
        StoreTypeE1 = 3'($urandom);
        funct3_E1 = 3'($urandom);
        BranchE1 = 1'b0;
        JumpE1 = 1'b0;
        JalrE1 = 1'b0;
        exp_pass = {WriteDataE1, PCPlus4E1, RD_E1, RegWriteE1, MemWriteE1, ResultSrcE1, LoadTypeE1, StoreTypeE1};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(5'd0, 32'd5, 32'd6);
        @(posedge clk);
        #1;
        checks++;
        if ({ALU_ResultM, m_pass} !== 111'd0) begin
            failures++;
            $display("FAIL reset_m got=%h exp=0", {ALU_ResultM, m_pass});
        end
        checks++;
        if (StallE2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall got=%b exp=0", StallE2);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_random();
        logic [4:0] op;
        logic [31:0] exp;
        for (int i = 0; i < 80; i++) begin
            op = 5'($urandom_range(0, 31));
`ifdef RV32M_DIV_EN
            if (op >= 5'd14 && op <= 5'd17) op = 5'd18;
`endif
            drive(op, rnd_operand(), rnd_operand());
            exp = model_alu(op, Src_A_E1, Src_B_E1);
            #1;
            checks++;
            if (ALU_ResultE2 !== exp || StallE2 !== 1'b0) begin
                failures++;
                $display("FAIL alu_comb op=%0d a=%h b=%h got=%h stall=%b exp=%h", op, Src_A_E1, Src_B_E1, ALU_ResultE2, StallE2, exp);
            end
            @(posedge clk);
            #1;
            checks++;
            if (ALU_ResultM !== exp || m_pass !== exp_pass) begin
                failures++;
                $display("FAIL alu_m op=%0d got=%h/%h exp=%h/%h", op, ALU_ResultM, m_pass, exp, exp_pass);
            end
        end
    endtask

    task automatic test_directed();
        logic [4:0] ops [3] = '{5'd0, 5'd10, 5'd11};
        logic [31:0] as [3] = '{32'd12345, 32'd12345, 32'h8000_0000};
        logic [31:0] bs [3] = '{32'd6789, 32'd6789, 32'h8000_0000};
        logic [31:0] ex [3] = '{32'd19134, 32'h04FE_D79D, 32'h4000_0000};
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], as[i], bs[i]);
            #1;
            checks++;
            if (ALU_ResultE2 !== ex[i]) begin
                failures++;
                $display("FAIL directed_comb op=%0d got=%h exp=%h", ops[i], ALU_ResultE2, ex[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (ALU_ResultM !== ex[i] || RegWriteM !== 1'b1) begin
                failures++;
                $display("FAIL directed_m op=%0d got=%h rw=%b exp=%h rw=1", ops[i], ALU_ResultM, RegWriteM, ex[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] a, b, t;
        logic c, exp_src;
        for (int i = 0; i < 50; i++) begin
            a = rnd_operand();
            b = ($urandom_range(0, 2) == 0) ? a : rnd_operand();
            drive(5'd0, a, b);
            BranchE1 = 1'($urandom);
            JumpE1 = ($urandom_range(0, 4) == 0);
            JalrE1 = ($urandom_range(0, 4) == 0);
            case (funct3_E1)
                3'b000: c = a == b;
                3'b001: c = a != b;
                3'b100: c = $signed(a) < $signed(b);
                3'b101: c = !($signed(a) < $signed(b));
                3'b110: c = a < b;
                3'b111: c = !(a < b);
                default: c = 1'b0;
            endcase
            exp_src = (BranchE1 && c) || JumpE1 || JalrE1;
            t = JalrE1 ? a + Imm_Ext_E1 : PCE1 + Imm_Ext_E1;
            if (JalrE1) t[0] = 1'b0;
            #1;
            checks++;
            if (PCSrcE2 !== exp_src || PCTargetE2 !== t) begin
                failures++;
                $display("FAIL branch f3=%0d a=%h b=%h got=%b/%h exp=%b/%h", funct3_E1, a, b, PCSrcE2, PCTargetE2, exp_src, t);
            end
            @(posedge clk);
            #1;
        end
        drive(5'd0, 32'd3, 32'd3);
        BranchE1 = 1'b1;
        funct3_E1 = 3'b000;
        PCE1 = 32'h100;
        Imm_Ext_E1 = 32'h20;
        #1;
        checks++;
        if (PCSrcE2 !== 1'b1 || PCTargetE2 !== 32'h120) begin
            failures++;
            $display("FAIL beq got=%b/%h exp=1/00000120", PCSrcE2, PCTargetE2);
        end
        drive(5'd0, 32'h203, 32'd0);
        JalrE1 = 1'b1;
        Imm_Ext_E1 = 32'd0;
        #1;
        checks++;
        if (PCSrcE2 !== 1'b1 || PCTargetE2 !== 32'h202) begin
            failures++;
            $display("FAIL jalr got=%b/%h exp=1/00000202", PCSrcE2, PCTargetE2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_div_special();
        logic [4:0] ops [6] = '{5'd14, 5'd14, 5'd17, 5'd15, 5'd16, 5'd16};
        logic [31:0] as [6] = '{32'd5, 32'h8000_0000, 32'd5, 32'd7, 32'h8000_0000, 32'hFFFF_FFF7};
        logic [31:0] bs [6] = '{32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exp;
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], as[i], bs[i]);
            exp = model_alu(ops[i], as[i], bs[i]);
            #1;
            checks++;
            if (ALU_ResultE2 !== exp || StallE2 !== 1'b0) begin
                failures++;
                $display("FAIL div_special op=%0d a=%h b=%h got=%h stall=%b exp=%h stall=0", ops[i], as[i], bs[i], ALU_ResultE2, StallE2, exp);
            end
            @(posedge clk);
            #1;
            checks++;
            if (ALU_ResultM !== exp || m_pass !== exp_pass) begin
                failures++;
                $display("FAIL div_special_m op=%0d got=%h exp=%h", ops[i], ALU_ResultM, exp);
            end
        end
    endtask

`ifdef RV32M_DIV_EN
    task automatic test_div_iterative();
        logic [4:0] op;
        logic [31:0] a, b, exp;
        int cyc;
        for (int i = 0; i < 8; i++) begin
            if (i < 2) begin
                op = (i == 0) ? 5'd14 : 5'd16;
                a = -32'sd100;
                b = 32'd7;
            end else begin
                op = 5'(14 + $urandom_range(0, 3));
                a = $urandom;
                b = 32'($urandom_range(1, 1000));
                if ($urandom_range(0, 1) == 1) b = -b;
            end
            exp = (i == 0) ? -32'sd14 : (i == 1) ? -32'sd2 : model_alu(op, a, b);
            drive(op, a, b);
            JumpE1 = 1'b1;
            #1;
            cyc = 0;
            while (StallE2 === 1'b1 && cyc < 100) begin
                checks++;
                if (PCSrcE2 !== 1'b0) begin
                    failures++;
                    $display("FAIL div_redirect cyc=%0d got=%b exp=0", cyc, PCSrcE2);
                end
                @(posedge clk);
                #1;
                cyc++;
                checks++;
                if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
                    failures++;
                    $display("FAIL div_bubble cyc=%0d got=%b%b exp=00", cyc, RegWriteM, MemWriteM);
                end
            end
            checks++;
            if (cyc != 33) begin
                failures++;
                $display("FAIL div_stall_len op=%0d got=%0d exp=33", op, cyc);
            end
            checks++;
            if (ALU_ResultE2 !== exp) begin
                failures++;
                $display("FAIL div_done op=%0d a=%h b=%h got=%h exp=%h", op, a, b, ALU_ResultE2, exp);
            end
            @(posedge clk);
            #1;
            checks++;
            if (ALU_ResultM !== exp || m_pass !== exp_pass) begin
                failures++;
                $display("FAIL div_m op=%0d got=%h exp=%h", op, ALU_ResultM, exp);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        drive(5'd14, -32'sd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (StallE2 !== 1'b1) begin
            failures++;
            $display("FAIL mid_div_stall got=%b exp=1", StallE2);
        end
        rst = 1'b1;
        drive(5'd0, 32'd1, 32'd2);
        @(posedge clk);
        #1;
        checks++;
        if (StallE2 !== 1'b0 || {ALU_ResultM, m_pass} !== 111'd0) begin
            failures++;
            $display("FAIL mid_div_reset stall=%b m=%h exp stall=0 m=0", StallE2, {ALU_ResultM, m_pass});
        end
        rst = 1'b0;
        drive(5'd0, 32'd40, 32'd2);
        #1;
        checks++;
        if (StallE2 !== 1'b0 || ALU_ResultE2 !== 32'd42) begin
            failures++;
            $display("FAIL post_reset_add stall=%b got=%h exp stall=0 0000002a", StallE2, ALU_ResultE2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ALU_ResultM !== 32'd42 || m_pass !== exp_pass) begin
            failures++;
            $display("FAIL post_reset_add_m got=%h exp=0000002a", ALU_ResultM);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_alu_random();
        test_branch();
        test_div_special();
`ifdef RV32M_DIV_EN
        test_div_iterative();
        test_reset_mid_div();
`endif
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute2_stage.md
Name: execute2_stage

Overview:
- Second execute stage of the 6-stage RV32IM pipeline. It consumes the E1/E2 pipeline register contents (operands already forwarded and ALUSrc-muxed) and computes the ALU/M-extension result.
- Resolves branches and jumps, and drives the E2 result back to the E1 forwarding mux.
- Holds the E2/M pipeline register.
- Runs an iterative divider FSM. While the divider runs, the block asserts a stall and inserts bubbles downstream.

Parameters:
- DIV_CYCLES, 32, divider iterations (one quotient bit per cycle); must equal XLEN.
- XLEN, 32, datapath width.

Ports:
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- Src_A_E1, Src_B_E1  input  32 each  forwarded operand A; operand B (immediate already selected if ALUSrc)
- Imm_Ext_E1  input  32  sign-extended immediate
- WriteDataE1  input  32  forwarded rs2 store data
- ALUControlE1  input  5  operation code (see Behaviour)
- RD_E1  input  5  destination register
- RegWriteE1, MemWriteE1  input  1 each  write enables
- ResultSrcE1  input  2  writeback select
- BranchE1, JumpE1, JalrE1  input  1 each  control-flow class
- PCE1, PCPlus4E1  input  32 each  PC values
- LoadTypeE1, StoreTypeE1, funct3_E1  input  3 each  memory types; branch condition
- ALU_ResultE2  output  32  combinational result, forwarded to E1
- StallE2  output  1  hold PC/D/E1 and the E1/E2 register
- PCSrcE2  output  1  take redirect
- PCTargetE2  output  32  redirect target
- ALU_ResultM, WriteDataM, PCPlus4M  output  32 each  E2/M register
- RD_M  output  5
- RegWriteM, MemWriteM  output  1 each
- ResultSrcM  output  2
- LoadTypeM, StoreTypeM  output  3 each

Behaviour:
- ALUControl encodings:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLT, 00110 SLTU.
  - 00111 SLL, 01000 SRL, 01001 SRA; shift amount is B[4:0].
  - 01010 MUL (low 32), 01011 MULH, 01100 MULHSU, 01101 MULHU; single cycle, 64-bit product, upper half for the H variants.
  - 01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU.
  - 10010 PASSB.
  - Any other code returns 0.
- Branch condition on A vs B by funct3_E1: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; other codes are not-taken.
- PCSrcE2 = (BranchE1 & cond) | JumpE1 | JalrE1; combinational, forced 0 while StallE2=1.
- PCTargetE2 = JalrE1 ? ((A+Imm) & ~1) : PCE1+Imm_Ext_E1.
- Divider FSM states IDLE, BUSY, DONE:
  - IDLE: on a div/rem op that is not a special case, StallE2=1. Latch |A|, |B| and the sign flags, count=0, go to BUSY.
  - BUSY: restoring shift-subtract, one bit per cycle, StallE2=1. When count==DIV_CYCLES-1, go to DONE.
  - DONE: StallE2=0. ALU_ResultE2 = sign-corrected quotient or remainder. The E2/M register captures it; FSM returns to IDLE.
  - Total stall: DIV_CYCLES+1 cycles. The result is visible at M on the edge leaving DONE.
- Division special cases complete in one cycle with no stall:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = A.
  - Signed 0x80000000 / -1: quotient = 0x80000000, remainder = 0.
- E2/M register update on each clk edge:
  - rst: all M outputs cleared to 0.
  - StallE2=1: insert a bubble. RegWriteM=0 and MemWriteM=0; other fields don't-care but held at the previous value.
  - Otherwise: capture the result and pass-through fields.
- Reset mid-division: FSM returns to IDLE, count=0, StallE2 drops in the same cycle rst is sampled, and the M register clears.
- Upstream must hold the E1/E2 register stable while StallE2=1. The divider latches its operands at entry and does not re-sample them.
- Remainder sign follows the dividend; quotient sign = sign(A) XOR sign(B), for signed ops only.

Optional Feature:
- Macro RV32M_DIV_EN.
- Defined: the divider FSM is present as described above.
- Undefined: the FSM is removed. Codes 01110–10001 return 0 in one cycle and StallE2 is tied to 0.

Test Plan:
- ADD A=12345, B=6789 -> ALU_ResultE2=19134 same cycle; ALU_ResultM=19134 after 1 edge, RegWriteM=1.
- MULH A=0x80000000, B=0x80000000 -> 0x40000000; MUL A=12345, B=6789 -> 83810205 (0x04FED79D).
- DIV A=-100, B=7 -> StallE2 high for exactly 33 cycles with RegWriteM=0 throughout; then ALU_ResultM=-14. REM of the same operands -> -2.
- DIV A=5, B=0 -> 0xFFFFFFFF with no stall; DIV A=0x80000000, B=-1 -> 0x80000000; REMU A=5, B=0 -> 5.
- BEQ with A=B=3, PCE1=0x100, Imm=0x20 -> PCSrcE2=1, PCTargetE2=0x120. JALR with A=0x203, Imm=0 -> PCTargetE2=0x202.
- rst asserted at cycle 10 of a DIV -> next cycle StallE2=0 and all M outputs 0. A following ADD completes normally.
